demux_2out_32data_buf: RTL and testbench
========================================

Name: demux_2out_32data_buf

Overview:
- Buffered 1-to-2 demultiplexer. It is the write/steer counterpart of the 2-input 32-bit datapath mux.
- Accepts one 32-bit word per cycle on a valid/ready input channel and routes it by a select bit to one of two output channels.
- Each output channel has its own small FIFO, so a stalled consumer on one side never corrupts or reorders data on the other.
- Sits between a producer stage (e.g. result/writeback bus) and two consumers (e.g. register-file write port and memory store path).

Parameters:
- WIDTH, 32, data width of input and both outputs.
- DEPTH, 2, entries per output FIFO. Power of two, >= 2.
- PTR_W, 1, pointer width = log2(DEPTH). Count width is PTR_W+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word will be accepted this cycle.
- in_select  input  1  0 routes to out_0, 1 routes to out_1. Sampled with in_data.
- in_data  input  WIDTH  word to route.
- out_0_valid  output  1  out_0 FIFO non-empty.
- out_0_ready  input  1  consumer 0 takes head word.
- out_0_data  output  WIDTH  head of out_0 FIFO.
- out_1_valid / out_1_ready / out_1_data: same as out_0, for channel 1.
- out_0_count, out_1_count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: asynchronous, takes effect immediately when rst=1 regardless of clk.
  - All FIFO pointers and counts go to 0; out_x_valid=0; out_x_data=0.
  - in_ready is 0 while rst=1.
  - Any word in flight or buffered at reset is discarded. No partial transfers survive.
- Handshakes:
  - Input transfer occurs on a rising edge with in_valid & in_ready.
  - Output transfer occurs with out_x_valid & out_x_ready.
- in_ready = !rst & (count of selected FIFO < DEPTH). It depends combinationally on in_select only, never on in_valid.
- Write latency: a word accepted at edge N is visible on out_x_valid/out_x_data after edge N (1 cycle). There is no combinational in-to-out bypass.
- out_x_data shows the FIFO head when out_x_valid=1, and is forced to 0 when the FIFO is empty.
- Ordering:
  - Per channel, strict FIFO order.
  - No ordering guarantee between channels; each drains independently.
- Per-channel count update each edge: count + push − pop.
  - Push and pop in the same cycle leave count unchanged, and both are performed.
- Full FIFO: in_ready=0 for that select value.
  - A simultaneous pop does not open in_ready in the same cycle; space appears the next cycle.
  - The other channel still accepts if not full.
- Empty FIFO: out_x_valid=0. out_x_ready is ignored and the pointers do not move.
- Pointers wrap modulo DEPTH with no gap or duplicate at the wrap.
- in_select change while in_valid=1 and in_ready=0 is legal. in_ready is re-evaluated against the new target.
- Never drops or duplicates a word outside reset.

Optional Feature:
- Macro: DEMUX_ROUTE_CNT_EN.
- When defined, adds outputs route_cnt_0 and route_cnt_1, each 16 bits.
  - Each counts accepted input transfers routed to that channel.
  - Reset to 0; wraps 0xFFFF -> 0x0000.
  - Increments on the same edge as the push.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset then route: rst pulse; send 0xAA with sel=0, then 0xBB with sel=1.
  - After each edge, out_0_data=0xAA/valid=1 and out_1_data=0xBB/valid=1.
  - Both counts =1.
- Fill/backpressure: hold out_0_ready=0 and push 0x11, 0x22 to sel=0.
  - in_ready drops to 0 for sel=0, out_0_count=2.
  - Switching to sel=1 gives in_ready=1.
  - Releasing out_0_ready drains 0x11 then 0x22.
- Simultaneous push/pop at count=1 on channel 1 (head 0x33, push 0x44).
  - count stays 1, and the next head is 0x44.
- Wrap-around: stream 8 words 0x1..0x8 to sel=0 with out_0_ready=1 continuously.
  - Output order is 0x1..0x8 with no gaps, and count never exceeds 1.
- Mid-operation async reset: with out_1 holding 2 words, assert rst between clock edges.
  - out_1_valid=0, out_1_data=0, counts=0 and in_ready=0 before the next edge.
  - After release, a new push works normally.
- With DEMUX_ROUTE_CNT_EN: push 3 words to sel=0 and 2 to sel=1.
  - route_cnt_0=3, route_cnt_1=2.
  - Preload to 0xFFFF and push once: the counter reads 0x0000.

Source files
------------

// File: rtl/demux_2out_32data_buf.sv
// demux_2out_32data_buf: buffered 1-to-2 valid/ready demux with a small FIFO per output channel.
// Define DEMUX_ROUTE_CNT_EN to add per-channel 16-bit accepted-word counters (route_cnt_0/1).
module demux_2out_32data_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_select,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_0_valid,
   input  logic             out_0_ready,
   output logic [WIDTH-1:0] out_0_data,
   output logic             out_1_valid,
   input  logic             out_1_ready,
   output logic [WIDTH-1:0] out_1_data,
   output logic [PTR_W:0]   out_0_count,
   output logic [PTR_W:0]   out_1_count
`ifdef DEMUX_ROUTE_CNT_EN
   ,
   output logic [15:0]      route_cnt_0,
   output logic [15:0]      route_cnt_1
`endif
);
   localparam logic [PTR_W:0] full_cnt = (PTR_W+1)'(DEPTH);
   logic [1:0]            push, pop, out_ready;
   logic [1:0][PTR_W:0]   cnt;
   logic [1:0][WIDTH-1:0] head;
   assign out_ready = {out_1_ready, out_0_ready};
   // Registered count only: a same-cycle pop never reopens a full channel.
   assign in_ready  = !rst && ((in_select ? cnt[1] : cnt[0]) < full_cnt);
   assign push      = {2{in_valid & in_ready}} & {in_select, !in_select};
   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr, rd_ptr;
      logic [PTR_W:0]   count;
      assign cnt[c]  = count;
      assign pop[c]  = (count != '0) && out_ready[c];
      assign head[c] = (count != '0) ? mem[rd_ptr] : '0;
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[c]) wr_ptr <= wr_ptr + 1'b1;
            if (pop[c]) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push[c]} - {{PTR_W{1'b0}}, pop[c]};
         end
      always_ff @(posedge clk)
         if (push[c]) mem[wr_ptr] <= in_data;
   end
   assign out_0_valid = cnt[0] != '0;
   assign out_1_valid = cnt[1] != '0;
   assign out_0_data  = head[0];
   assign out_1_data  = head[1];
   assign out_0_count = cnt[0];
   assign out_1_count = cnt[1];
`ifdef DEMUX_ROUTE_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         route_cnt_0 <= '0;
         route_cnt_1 <= '0;
      end else begin
         if (push[0]) route_cnt_0 <= route_cnt_0 + 1'b1;
         if (push[1]) route_cnt_1 <= route_cnt_1 + 1'b1;
      end
`endif
endmodule

// File: tb/tb_demux_2out_32data_buf.sv
// tb_demux_2out_32data_buf: directed vector table, hand sequences and a queue-based random check.
module tb_demux_2out_32data_buf;
   localparam int D = 2;
   logic        clk = 0, rst = 0, in_valid = 0, in_select = 0, out_0_ready = 0, out_1_ready = 0;
   logic [31:0] in_data = 0;
   logic        in_ready, out_0_valid, out_1_valid;
   logic [31:0] out_0_data, out_1_data;
   logic [1:0]  out_0_count, out_1_count;
`ifdef DEMUX_ROUTE_CNT_EN
   logic [15:0] route_cnt_0, route_cnt_1;
`endif
   int n_cmp = 0, n_err = 0;

   demux_2out_32data_buf #(.WIDTH(32), .DEPTH(D), .PTR_W(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select),
      .in_data(in_data), .out_0_valid(out_0_valid), .out_0_ready(out_0_ready),
      .out_0_data(out_0_data), .out_1_valid(out_1_valid), .out_1_ready(out_1_ready),
      .out_1_data(out_1_data), .out_0_count(out_0_count), .out_1_count(out_1_count)
`ifdef DEMUX_ROUTE_CNT_EN
      , .route_cnt_0(route_cnt_0), .route_cnt_1(route_cnt_1)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vld, sel; logic [31:0] data; logic r0, r1, e_rdy;
      int c0; logic [31:0] d0; int c1; logic [31:0] d1;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int c0, input logic [31:0] d0,
                            input int c1, input logic [31:0] d1);
      chk({tag, ".c0"}, 32'(out_0_count), 32'(c0));
      chk({tag, ".v0"}, 32'(out_0_valid), 32'(c0 != 0));
      chk({tag, ".d0"}, out_0_data, d0);
      chk({tag, ".c1"}, 32'(out_1_count), 32'(c1));
      chk({tag, ".v1"}, 32'(out_1_valid), 32'(c1 != 0));
      chk({tag, ".d1"}, out_1_data, d1);
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d, input logic r0, input logic r1);
      @(negedge clk);
      in_valid = v; in_select = s; in_data = d; out_0_ready = r0; out_1_ready = r1;
   endtask

   task automatic reset_pulse();
      drive(0, 0, 0, 0, 0);
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      logic [31:0] q0[$], q1[$];
      logic        e_rdy;
      int          rc0, rc1;
      tbl[0]  = '{1'b1, 1'b0, 32'hAA, 1'b0, 1'b0, 1'b1, 1, 32'hAA, 0, 32'h0};
      tbl[1]  = '{1'b1, 1'b1, 32'hBB, 1'b0, 1'b0, 1'b1, 1, 32'hAA, 1, 32'hBB};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 0, 32'h0,  0, 32'h0};
      tbl[3]  = '{1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b1, 1, 32'h11, 0, 32'h0};
      tbl[4]  = '{1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b1, 2, 32'h11, 0, 32'h0};
      tbl[5]  = '{1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 2, 32'h11, 0, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 2, 32'h11, 0, 32'h0};
      tbl[7]  = '{1'b1, 1'b0, 32'h66, 1'b1, 1'b0, 1'b0, 1, 32'h22, 0, 32'h0};
      tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 0, 32'h0,  0, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 0, 32'h0,  1, 32'h33};
      tbl[10] = '{1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 0, 32'h0,  1, 32'h44};
      tbl[11] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 1'b1, 0, 32'h0,  0, 32'h0};
      tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 0, 32'h0,  0, 32'h0};

      #1 rst = 1;
      #2;
      chk("reset.rdy", 32'(in_ready), 32'h0);
      chk_state("reset", 0, 0, 0, 0);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].r0, tbl[i].r1);
         #1 chk($sformatf("tbl%0d.rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         @(posedge clk);
         #1 chk_state($sformatf("tbl%0d", i), tbl[i].c0, tbl[i].d0, tbl[i].c1, tbl[i].d1);
      end

      for (int i = 1; i <= 8; i++) begin
         drive(1, 0, 32'(i), 1, 0);
         @(posedge clk);
         #1 chk_state($sformatf("wrap%0d", i), 1, 32'(i), 0, 0);
      end
      drive(0, 0, 0, 1, 0);
      @(posedge clk);
      #1 chk_state("wrap_end", 0, 0, 0, 0);

      drive(1, 1, 32'hC1, 0, 0);
      @(posedge clk);
      drive(1, 1, 32'hC2, 0, 0);
      @(posedge clk);
      #1 chk_state("pre_rst", 0, 0, 2, 32'hC1);
      #1 rst = 1;
      #1 chk("async_rst.rdy", 32'(in_ready), 32'h0);
      chk_state("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 0; in_data = 32'hD1;
      @(posedge clk);
      #1 chk_state("post_rst", 0, 0, 1, 32'hD1);
      drive(0, 0, 0, 0, 1);
      @(posedge clk);
      #1 chk_state("post_rst_drain", 0, 0, 0, 0);

      reset_pulse();
      rc0 = 0; rc1 = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         in_valid    = $urandom_range(0, 3) != 0;
         in_select   = 1'($urandom);
         in_data     = $urandom;
         out_0_ready = $urandom_range(0, 2) == 0;
         out_1_ready = $urandom_range(0, 2) == 0;
         #1;
         e_rdy = (in_select ? q1.size() : q0.size()) < D;
         chk($sformatf("rnd%0d.rdy", k), 32'(in_ready), 32'(e_rdy));
         chk_state($sformatf("rnd%0d", k), q0.size(), q0.size() != 0 ? q0[0] : 32'h0,
                   q1.size(), q1.size() != 0 ? q1[0] : 32'h0);
`ifdef DEMUX_ROUTE_CNT_EN
         chk($sformatf("rnd%0d.rc0", k), 32'(route_cnt_0), 32'(rc0 % 65536));
         chk($sformatf("rnd%0d.rc1", k), 32'(route_cnt_1), 32'(rc1 % 65536));
`endif
         if (out_0_ready && q0.size() != 0) void'(q0.pop_front());
         if (out_1_ready && q1.size() != 0) void'(q1.pop_front());
         if (in_valid && e_rdy) begin
            if (in_select) begin q1.push_back(in_data); rc1++; end
            else begin q0.push_back(in_data); rc0++; end
         end
      end

`ifdef DEMUX_ROUTE_CNT_EN
      reset_pulse();
      for (int i = 0; i < 5; i++) begin
         drive(1, i >= 3, 32'(i), 1, 1);
         @(posedge clk);
      end
      drive(0, 0, 0, 1, 1);
      @(posedge clk);
      #1 chk("route_cnt_0", 32'(route_cnt_0), 32'd3);
      chk("route_cnt_1", 32'(route_cnt_1), 32'd2);
      drive(1, 0, 32'h5A, 1, 1);
      repeat (65532) @(posedge clk);
      #1 chk("route_cnt_0_max", 32'(route_cnt_0), 32'hFFFF);
      @(posedge clk);
      #1 chk("route_cnt_0_wrap", 32'(route_cnt_0), 32'h0);
      chk("route_cnt_1_hold", 32'(route_cnt_1), 32'd2);
      in_valid = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
